// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction-fetch port, load/store port and
// the byte-wide RAM/IO bus. The arbiter uses the slave modport; the
// requesters and the RAM side use the master modport.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a load/store port
// onto a byte-serial RAM/IO bus. Transfers are 1, 2 or 4 bytes, little-endian.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break IF/MEM ties in
// favour of the port not granted last; otherwise MEM always beats IF.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              sel_mem_q, sel_mem_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              rdy_q;

  logic              grant_mem;
  logic              grant_any;
  logic [1:0]        idx_nx;
  logic [31:0]       asm_word;

  function automatic logic [1:0] last_of(input logic [1:0] len);
    case (len)
      2'b00:   last_of = 2'd0;
      2'b01:   last_of = 2'd1;
      default: last_of = 2'd3;
    endcase
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lg_mem_q, lg_mem_d;
  assign grant_mem = bus.mem_req & (~bus.if_req | ~lg_mem_q);
`else
  assign grant_mem = bus.mem_req;
`endif
  assign grant_any = bus.mem_req | bus.if_req;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; everything except rdy_q is frozen via the
  // next-state logic while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q      <= '0;
      last_q      <= '0;
      wdata_q     <= '0;
      sel_mem_q   <= 1'b0;
      idx_q       <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      rdy_q       <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lg_mem_q    <= 1'b0;
`endif
    end else begin
      addr_q      <= addr_d;
      last_q      <= last_d;
      wdata_q     <= wdata_d;
      sel_mem_q   <= sel_mem_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      rdy_q       <= rdy_in;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lg_mem_q    <= lg_mem_d;
`endif
    end
  end

  // Next-state, grant and byte-sequencing logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    wdata_d     = wdata_q;
    sel_mem_d   = sel_mem_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    done_d      = done_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    lg_mem_d    = lg_mem_q;
`endif
    idx_nx      = idx_q + 2'd1;
    asm_word    = buf_q;
    asm_word[{idx_q, 3'b000} +: 8] = bus.ram_din;

    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            sel_mem_d = grant_mem;
            addr_d    = grant_mem ? bus.mem_addr : bus.if_addr;
            ram_a_d   = grant_mem ? bus.mem_addr : bus.if_addr;
            last_d    = grant_mem ? last_of(bus.mem_len) : 2'd3;
            wdata_d   = bus.mem_wdata;
            buf_d     = '0;
            idx_d     = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lg_mem_d  = grant_mem;
`endif
            if (grant_mem && bus.mem_we) begin
              state_d = WRITE;
              dout_d  = bus.mem_wdata[7:0];
              wr_d    = 1'b1;
              done_d  = (last_of(bus.mem_len) == 2'd0);
            end else begin
              state_d = READ;
            end
          end
        end
        READ: begin
          if (done_q) begin
            done_d  = 1'b0;
            state_d = IDLE;
          end else if (rdy_q) begin
            // A low rdy_q marks the first edge after a stall: the address is
            // re-presented for one cycle and that edge's capture is dropped.
            buf_d = asm_word;
            if (idx_q == last_q) begin
              done_d = 1'b1;
              if (sel_mem_q) mem_rdata_d = asm_word;
              else           if_data_d   = asm_word;
            end else begin
              idx_d   = idx_nx;
              ram_a_d = addr_q + ADDR_W'(idx_nx);
            end
          end
        end
        WRITE: begin
          if (done_q) begin
            done_d  = 1'b0;
            wr_d    = 1'b0;
            dout_d  = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_nx;
            ram_a_d = addr_q + ADDR_W'(idx_nx);
            dout_d  = wdata_q[{idx_nx, 3'b000} +: 8];
            done_d  = (idx_nx == last_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ram_wr    = wr_q & rdy_in;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = dout_q;
  assign bus.if_done   = done_q & ~sel_mem_q;
  assign bus.mem_done  = done_q & sel_mem_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4 KB byte RAM model
// (address bits [11:0]) and a log of every byte written on the RAM bus.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic rdy;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  logic [7:0]  ram_m [0:4095];
  logic [31:0] wr_a_q [$];
  logic [7:0]  wr_d_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int total;
  int n0;
  logic exp_mem_first;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_din = ram_m[bus.ram_a[11:0]];

  always @(posedge clk) begin
    if (bus.ram_wr) begin
      wr_a_q.push_back(bus.ram_a);
      wr_d_q.push_back(bus.ram_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_any(input string tag, output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!(bus.if_done || bus.mem_done) && c < 40);
    chk({tag, "_timeout"}, {31'b0, bus.if_done | bus.mem_done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram_m[i] = 8'h00;
    ram_m[12'h100] = 8'h13; ram_m[12'h101] = 8'h05; ram_m[12'h102] = 8'h00; ram_m[12'h103] = 8'h00;
    ram_m[12'h104] = 8'h93; ram_m[12'h105] = 8'h00; ram_m[12'h106] = 8'h10; ram_m[12'h107] = 8'h00;
    ram_m[12'h200] = 8'h11; ram_m[12'h201] = 8'h22; ram_m[12'h202] = 8'h33; ram_m[12'h203] = 8'h44;
    ram_m[12'h002] = 8'hFF; ram_m[12'h003] = 8'h80;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_len = 2'b00; bus.mem_wdata = '0;
    rdy = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;

    // Reset values
    chk("rst_ram_wr", {31'b0, bus.ram_wr}, 32'd0);
    chk("rst_ram_a", bus.ram_a, 32'h0);
    chk("rst_ram_dout", {24'b0, bus.ram_dout}, 32'h0);
    chk("rst_done", {30'b0, bus.if_done, bus.mem_done}, 32'd0);
    chk("rst_if_data", bus.if_data, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Instruction fetch word at 0x100
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    chk("if_a0", bus.ram_a, 32'h100);
    chk("if_wr0", {31'b0, bus.ram_wr}, 32'd0);
    bus.if_req = 1'b0; bus.if_addr = 32'hDEAD0000;
    tick(); chk("if_a1", bus.ram_a, 32'h101);
    tick(); chk("if_a2", bus.ram_a, 32'h102);
    tick(); chk("if_a3", bus.ram_a, 32'h103);
    chk("if_nodone_e3", {31'b0, bus.if_done}, 32'd0);
    tick();
    chk("if_done_e4", {31'b0, bus.if_done}, 32'd1);
    chk("if_data", bus.if_data, 32'h00000513);
    chk("if_a_hold", bus.ram_a, 32'h103);
    tick();
    chk("if_done_pulse", {31'b0, bus.if_done}, 32'd0);

    // Byte store into IO space
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b00;
    bus.mem_addr = 32'h30000; bus.mem_wdata = 32'hAABBCC41;
    n0 = wr_a_q.size();
    tick();
    chk("st_wr", {31'b0, bus.ram_wr}, 32'd1);
    chk("st_a", bus.ram_a, 32'h30000);
    chk("st_dout", {24'b0, bus.ram_dout}, 32'h41);
    chk("st_done", {31'b0, bus.mem_done}, 32'd1);
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    tick();
    chk("st_wr_off", {31'b0, bus.ram_wr}, 32'd0);
    chk("st_done_off", {31'b0, bus.mem_done}, 32'd0);
    chk("idle_dout", {24'b0, bus.ram_dout}, 32'h0);
    chk("idle_a_hold", bus.ram_a, 32'h30000);
    chk("st_count", 32'(wr_a_q.size() - n0), 32'd1);
    chk("st_log", {wr_a_q[n0][23:0], wr_d_q[n0]}, {24'h030000, 8'h41});

    // Tie: MEM word load vs IF fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b10; bus.mem_addr = 32'h200;
    wait_any("tie1", cyc);
    chk("tie1_cyc", cyc, 32'd5);
    chk("tie1_who", {30'b0, bus.mem_done, bus.if_done}, 32'b10);
    chk("tie1_rdata", bus.mem_rdata, 32'h44332211);
    bus.mem_req = 1'b0;
    tick();
    bus.mem_req = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_mem_first = 1'b0;
`else
    exp_mem_first = 1'b1;
`endif
    wait_any("tie2", cyc);
    chk("tie2_cyc", cyc, 32'd5);
    chk("tie2_who", {30'b0, bus.mem_done, bus.if_done}, exp_mem_first ? 32'b10 : 32'b01);
    if (exp_mem_first) bus.mem_req = 1'b0; else bus.if_req = 1'b0;
    tick();
    wait_any("tie3", cyc);
    chk("tie3_cyc", cyc, 32'd5);
    chk("tie3_who", {30'b0, bus.mem_done, bus.if_done}, exp_mem_first ? 32'b01 : 32'b10);
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    chk("tie_if_data", bus.if_data, 32'h00100093);
    chk("tie_mem_rdata", bus.mem_rdata, 32'h44332211);
    tick();

    // Half load, byte load, len=11 load from IO space
    bus.mem_req = 1'b1; bus.mem_len = 2'b01; bus.mem_addr = 32'h1002;
    wait_any("half", cyc);
    chk("half_cyc", cyc, 32'd3);
    chk("half_rdata", bus.mem_rdata, 32'h000080FF);
    bus.mem_req = 1'b0;
    tick();
    bus.mem_req = 1'b1; bus.mem_len = 2'b00; bus.mem_addr = 32'h203;
    wait_any("byte", cyc);
    chk("byte_cyc", cyc, 32'd2);
    chk("byte_rdata", bus.mem_rdata, 32'h00000044);
    bus.mem_req = 1'b0;
    tick();
    bus.mem_req = 1'b1; bus.mem_len = 2'b11; bus.mem_addr = 32'h30200;
    wait_any("len3", cyc);
    chk("len3_cyc", cyc, 32'd5);
    chk("len3_rdata", bus.mem_rdata, 32'h44332211);
    bus.mem_req = 1'b0;
    tick();

    // Word fetch with rdy low for 3 cycles after byte 0 is captured
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    bus.if_req = 1'b0;
    tick();
    chk("stall_a1", bus.ram_a, 32'h101);
    rdy = 1'b0;
    #1 chk("stall_wr", {31'b0, bus.ram_wr}, 32'd0);
    total = 2;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      chk("stall_a_hold", bus.ram_a, 32'h101);
    end
    rdy = 1'b1;
    wait_any("stall_rd", cyc);
    chk("stall_rd_cyc", total + cyc, 32'd9);
    chk("stall_rd_data", bus.if_data, 32'h00000513);
    tick();

    // Word store with rdy low for 2 cycles during byte 1
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
    bus.mem_addr = 32'h400; bus.mem_wdata = 32'hDEADBEEF;
    n0 = wr_a_q.size();
    tick();
    chk("wst_d0", {24'b0, bus.ram_dout}, 32'hEF);
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_wdata = 32'h0;
    tick();
    chk("wst_a1", bus.ram_a, 32'h401);
    rdy = 1'b0;
    #1 chk("wst_wr_gated", {31'b0, bus.ram_wr}, 32'd0);
    tick();
    chk("wst_wr_gated2", {31'b0, bus.ram_wr}, 32'd0);
    tick();
    rdy = 1'b1;
    #1 chk("wst_resume", {bus.ram_wr, 15'b0, bus.ram_a[7:0], bus.ram_dout}, {1'b1, 15'b0, 8'h01, 8'hBE});
    wait_any("wst", cyc);
    chk("wst_cyc", cyc, 32'd2);
    chk("wst_last", {bus.ram_wr, bus.mem_done, 14'b0, bus.ram_a[7:0], bus.ram_dout}, {2'b11, 14'b0, 8'h03, 8'hDE});
    tick();
    chk("wst_count", 32'(wr_a_q.size() - n0), 32'd4);
    chk("wst_bytes", {wr_d_q[n0+3], wr_d_q[n0+2], wr_d_q[n0+1], wr_d_q[n0]}, 32'hDEADBEEF);
    chk("wst_a_last", wr_a_q[n0+3], 32'h403);

    // Reset in the middle of a word store
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
    bus.mem_addr = 32'h500; bus.mem_wdata = 32'h11223344;
    n0 = wr_a_q.size();
    tick();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    tick(); tick();
    chk("rst_mid_pre", {bus.ram_wr, 23'b0, bus.ram_a[7:0]}, {1'b1, 23'b0, 8'h02});
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", {31'b0, bus.ram_wr}, 32'd0);
    chk("rst_mid_a", bus.ram_a, 32'h0);
    chk("rst_mid_rdata", bus.if_data | bus.mem_rdata, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_done", {30'b0, bus.if_done, bus.mem_done}, 32'd0);
      tick();
    end
    chk("rst_mid_count", 32'(wr_a_q.size() - n0), 32'd2);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_any("post_rst", cyc);
    chk("post_rst_cyc", cyc, 32'd5);
    chk("post_rst_data", {bus.if_done, bus.if_data[30:0]}, {1'b1, 31'h00000513});
    bus.if_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of every address port.
REQ-002 clk_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 rdy_in  input  1  SHALL be the global ready; low pauses the block.
REQ-005 if_req  input  1 / if_addr  input  ADDR_W: instruction-fetch request (always a 4-byte read) and its byte address.
REQ-006 if_done  output  1 / if_data  output  32: one-cycle completion pulse and fetched word.
REQ-007 mem_req  input  1 / mem_we  input  1 / mem_addr  input  ADDR_W: load/store request, write flag, byte address.
REQ-008 mem_len  input  2  SHALL encode the access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 mem_wdata  input  32: store data, little-endian, low bytes used for byte and half stores.
REQ-010 mem_done  output  1 / mem_rdata  output  32: one-cycle completion pulse and zero-extended load data.
REQ-011 ram_din  input  8 / ram_dout  output  8 / ram_a  output  ADDR_W / ram_wr  output  1: byte-wide RAM/IO bus (ram_wr 1 = write).

Function
REQ-012 The block SHALL have the states IDLE, READ and WRITE.
REQ-013 In IDLE with rdy_in=1, a pending request SHALL be granted at edge E0, latching the address, length, data and requester, and entering READ or WRITE.
REQ-014 Requests SHALL be level-sensitive and sampled only in IDLE; inputs changing after grant SHALL have no effect.
REQ-015 Without the configuration macro, mem_req SHALL win over if_req when both are pending.
REQ-016 Transfers SHALL be byte-serial, N = 1, 2 or 4 bytes; byte n SHALL use ram_a = A+n (wrap modulo 2^ADDR_W).
REQ-017 READ: ram_a=A+n SHALL be driven in the cycle after edge E_n for n<N; ram_a SHALL then hold A+N-1.
REQ-018 READ: ram_din sampled at E_(n+1) SHALL be byte n; done and data SHALL be valid in the cycle after E_N, so a word read completes 5 cycles after the request cycle.
REQ-019 WRITE: ram_a=A+n, ram_dout=byte n and ram_wr=1 SHALL be driven in the cycle after E_n.
REQ-020 WRITE: done SHALL be high in the same cycle as the last byte; ram_wr SHALL be 0 from E_N.
REQ-021 Read data SHALL be assembled little-endian; half and byte results SHALL be zero-extended.
REQ-022 if_data and mem_rdata SHALL hold their value until that port's next read completion.
REQ-023 After the done cycle the block SHALL return to IDLE; the earliest next grant SHALL be one edge later.
REQ-024 Requesters SHALL drop req by the edge that follows their done pulse.
REQ-025 In IDLE, ram_wr SHALL be 0, ram_a SHALL hold its last value, and ram_dout SHALL be 0.
REQ-026 While rdy_in=0, no state, counter, capture or done SHALL change.
REQ-027 While rdy_in=0, ram_wr SHALL be forced to 0 combinationally (ram_wr = wr_reg AND rdy_in).
REQ-028 On the first cycle after rdy_in returns high during READ, the current address SHALL be re-presented, the capture at that edge SHALL be discarded, and byte capture SHALL resume one edge later.
REQ-029 Writes interrupted by rdy_in=0 SHALL resume on the same byte with no byte written twice.
REQ-030 The block SHALL be address-agnostic; IO space (addr[17:16]=11) SHALL be handled like RAM.

Reset
REQ-031 On rst_in=1, immediately and regardless of clock or rdy_in: state=IDLE; ram_wr, ram_dout, ram_a, if_done, mem_done = 0; if_data, mem_rdata = 0; last-grant = IF.
REQ-032 A reset mid-transfer SHALL abort it silently: no done pulse, and no further bytes after reset asserts.

Configuration
REQ-033 Macro MEM_ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, the port not granted last SHALL win (reset last-grant = IF, so MEM wins the first tie).
REQ-034 MEM_ARB_ROUND_ROBIN_EN undefined: fixed MEM-over-IF priority; the last-grant register SHALL not exist.

Verification
REQ-035 if_req, if_addr=0x100, RAM 0x100..0x103 = 13,05,00,00 -> ram_a 0x100..0x103 on consecutive cycles, ram_wr=0, if_done after E4, if_data=0x00000513.
REQ-036 mem store, len=00, addr=0x30000, wdata=0x41 -> exactly one cycle with ram_wr=1, ram_a=0x30000, ram_dout=0x41, mem_done in that cycle.
REQ-037 if_req and mem_req both asserted (mem word load) -> MEM done first, then IF granted. With MEM_ARB_ROUND_ROBIN_EN, a second simultaneous tie -> IF wins.
REQ-038 mem half load at 0x1002, bytes FF,80 -> mem_rdata=0x000080FF.
REQ-039 rdy_in low for 3 cycles after byte 1 of a word read -> ram_wr stays 0, data correct, done 4 cycles later than nominal.
REQ-040 rst_in pulsed after 2 bytes of a word store -> ram_wr=0 at once, no mem_done; the next word read completes in 5 cycles.
